// File: rtl/fpu_seq.sv
// Sequencer handing one decoded FPU instruction at a time to an iterative FPU and writing its result back.
// Optional FPU_SEQ_TIMEOUT_EN adds a WAIT-state watchdog that abandons the op and pulses err.
module fpu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  FPUControl,
  input  logic        FPUFlagW,
  input  logic [3:0]  Rd,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  input  logic [1:0]  fpu_flags,
  output logic        stall,
  output logic        wb_en,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        flag_we,
  output logic [1:0]  flags_out,
  output logic        busy,
  output logic [7:0]  lat_cnt,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t state;
  logic   flagw_q;
`ifdef FPU_SEQ_TIMEOUT_EN
  logic [5:0] wd_cnt;
`endif

  // Stall must cover the request cycle itself so decode does not advance past it.
  assign stall = (state == IDLE && req) || state == ISSUE || state == WAIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flagw_q   <= 1'b0;
      fpu_start <= 1'b0;
      fpu_op    <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      flag_we   <= 1'b0;
      flags_out <= '0;
      busy      <= 1'b0;
      lat_cnt   <= '0;
      err       <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
      wd_cnt    <= '0;
`endif
    end else begin
      fpu_start <= 1'b0;
      wb_en     <= 1'b0;
      flag_we   <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state     <= ISSUE;
            fpu_op    <= FPUControl;
            flagw_q   <= FPUFlagW;
            wb_rd     <= Rd;
            fpu_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          state   <= WAIT;
          lat_cnt <= '0;
`ifdef FPU_SEQ_TIMEOUT_EN
          wd_cnt  <= '0;
`endif
        end
        WAIT: begin
          if (fpu_done) begin
            state     <= WB;
            wb_data   <= fpu_result;
            flags_out <= fpu_flags;
            wb_en     <= 1'b1;
            flag_we   <= flagw_q;
          end else begin
            if (lat_cnt != 8'hFF) lat_cnt <= lat_cnt + 8'd1;
`ifdef FPU_SEQ_TIMEOUT_EN
            wd_cnt <= wd_cnt + 6'd1;
            if (wd_cnt == 6'h3F) begin
              state <= IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
`endif
          end
        end
        WB: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq.sv
// Self-checking bench for fpu_seq: directed scenarios plus randomized instructions against a transaction-level model.
module tb_fpu_seq;
  logic        clk = 1'b0;
  logic        reset, req, FPUFlagW, fpu_done;
  logic [1:0]  FPUControl, fpu_flags;
  logic [3:0]  Rd;
  logic [31:0] fpu_result;
  logic        fpu_start, stall, wb_en, flag_we, busy, err;
  logic [1:0]  fpu_op, flags_out;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [7:0]  lat_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] last_op = 2'b00;

  fpu_seq dut (
    .clk(clk), .reset(reset), .req(req), .FPUControl(FPUControl), .FPUFlagW(FPUFlagW), .Rd(Rd),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_done(fpu_done), .fpu_result(fpu_result),
    .fpu_flags(fpu_flags), .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_we(flag_we), .flags_out(flags_out), .busy(busy), .lat_cnt(lat_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; FPUControl = '0; FPUFlagW = 1'b0; Rd = '0;
    fpu_done = 1'b0; fpu_result = '0; fpu_flags = '0;
    step(); step();
    reset = 1'b0;
    #1;
    n_cmp++; if ({fpu_start, fpu_op, stall, wb_en, wb_rd, flag_we, flags_out, busy, lat_cnt, err} !== '0)
      begin n_bad++; $display("FAIL reset_ctl got start=%b op=%b stall=%b wb=%b rd=%h fw=%b fl=%b busy=%b lat=%0d err=%b want all 0",
        fpu_start, fpu_op, stall, wb_en, wb_rd, flag_we, flags_out, busy, lat_cnt, err); end
    n_cmp++; if (wb_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", wb_data); end
    last_op = 2'b00;
  endtask

  // One full instruction from the IDLE cycle; model: wb 3+delay cycles after req, lat_cnt = min(delay,255).
  task automatic do_txn(input logic [1:0] op, input logic [3:0] rd, input logic fw, input int delay,
                        input logic [31:0] res, input logic [1:0] flg, input bit hold);
    int exp_lat;
    exp_lat = (delay > 255) ? 255 : delay;
    req = 1'b1; FPUControl = op; FPUFlagW = fw; Rd = rd; fpu_done = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL req_stall got %b want 1", stall); end
    n_cmp++; if (fpu_op !== last_op) begin n_bad++; $display("FAIL op_before_latch got %b want %b", fpu_op, last_op); end
    step();
    if (!hold) req = 1'b0;
    FPUControl = 2'($urandom); Rd = 4'($urandom); FPUFlagW = 1'($urandom);
    fpu_done = 1'($urandom); fpu_result = $urandom;
    #1;
    n_cmp++; if (fpu_start !== 1'b1) begin n_bad++; $display("FAIL issue_start got %b want 1", fpu_start); end
    n_cmp++; if (fpu_op !== op) begin n_bad++; $display("FAIL issue_op got %b want %b", fpu_op, op); end
    n_cmp++; if ({busy, stall, wb_en} !== 3'b110) begin n_bad++; $display("FAIL issue_ctl got busy/stall/wb=%b want 110", {busy, stall, wb_en}); end
    last_op = op;
    step();
    fpu_done = 1'b0;
    for (int i = 0; i < delay; i++) begin
      #1;
      n_cmp++; if ({fpu_start, stall, wb_en, busy, fpu_op} !== {4'b0101, op})
        begin n_bad++; $display("FAIL wait_ctl got start/stall/wb/busy/op=%b want 0101%b", {fpu_start, stall, wb_en, busy, fpu_op}, op); end
      step();
    end
    fpu_done = 1'b1; fpu_result = res; fpu_flags = flg;
    step();
    fpu_done = 1'($urandom); fpu_result = $urandom; fpu_flags = 2'($urandom);
    #1;
    n_cmp++; if (wb_en !== 1'b1) begin n_bad++; $display("FAIL wb_en got %b want 1", wb_en); end
    n_cmp++; if (wb_rd !== rd) begin n_bad++; $display("FAIL wb_rd got %h want %h", wb_rd, rd); end
    n_cmp++; if (wb_data !== res) begin n_bad++; $display("FAIL wb_data got %h want %h", wb_data, res); end
    n_cmp++; if (flag_we !== fw) begin n_bad++; $display("FAIL flag_we got %b want %b", flag_we, fw); end
    n_cmp++; if (flags_out !== flg) begin n_bad++; $display("FAIL flags_out got %b want %b", flags_out, flg); end
    n_cmp++; if (lat_cnt !== 8'(exp_lat)) begin n_bad++; $display("FAIL lat_cnt got %0d want %0d", lat_cnt, exp_lat); end
    n_cmp++; if ({stall, busy, fpu_start, err} !== 4'b0100) begin n_bad++; $display("FAIL wb_ctl got stall/busy/start/err=%b want 0100", {stall, busy, fpu_start, err}); end
    step();
    fpu_done = 1'b0;
    #1;
    n_cmp++; if ({wb_en, flag_we, busy, fpu_start} !== 4'b0000) begin n_bad++; $display("FAIL post_wb_ctl got wb/fw/busy/start=%b want 0000", {wb_en, flag_we, busy, fpu_start}); end
    n_cmp++; if (stall !== hold) begin n_bad++; $display("FAIL post_wb_stall got %b want %b", stall, hold); end
    n_cmp++; if (wb_data !== res || lat_cnt !== 8'(exp_lat)) begin n_bad++; $display("FAIL post_wb_hold got data=%h lat=%0d want %h %0d", wb_data, lat_cnt, res, exp_lat); end
  endtask

  task automatic test_mul_directed();
    do_txn(2'b10, 4'd3, 1'b1, 4, 32'h3F800000, 2'b01, 1'b0);
  endtask

  task automatic test_fast_noflags();
    do_txn(2'b01, 4'd9, 1'b0, 0, 32'hC0490FDB, 2'b10, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_txn(2'b00, 4'd1, 1'b1, 1, 32'h12345678, 2'b00, 1'b1);
    do_txn(2'b11, 4'd14, 1'b1, 2, 32'h9ABCDEF0, 2'b11, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    req = 1'b1; FPUControl = 2'b11; Rd = 4'd7; FPUFlagW = 1'b1;
    step();
    req = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0; fpu_done = 1'b1; fpu_result = 32'hDEADBEEF; fpu_flags = 2'b11;
    #1;
    n_cmp++; if ({fpu_start, fpu_op, stall, wb_en, wb_rd, flag_we, flags_out, busy, lat_cnt, err} !== '0)
      begin n_bad++; $display("FAIL rst_wait_ctl got start=%b op=%b stall=%b wb=%b rd=%h fw=%b busy=%b lat=%0d", fpu_start, fpu_op, stall, wb_en, wb_rd, flag_we, busy, lat_cnt); end
    step();
    fpu_done = 1'b0;
    #1;
    n_cmp++; if ({wb_en, flag_we, busy, stall, fpu_start} !== 5'b0) begin n_bad++; $display("FAIL rst_wait_after got wb/fw/busy/stall/start=%b want 00000", {wb_en, flag_we, busy, stall, fpu_start}); end
    n_cmp++; if (wb_data !== 32'h0 || flags_out !== 2'b00) begin n_bad++; $display("FAIL rst_wait_data got %h %b want 0 0", wb_data, flags_out); end
    last_op = 2'b00;
  endtask

  task automatic test_spurious_idle();
    logic [31:0] held;
    held = wb_data;
    for (int i = 0; i < 3; i++) begin
      fpu_done = 1'b1; fpu_result = $urandom; fpu_flags = 2'($urandom);
      step();
      n_cmp++; if ({wb_en, flag_we, busy, fpu_start, stall} !== 5'b0 || wb_data !== held)
        begin n_bad++; $display("FAIL idle_done got wb/fw/busy/start/stall=%b data=%h want 00000 %h", {wb_en, flag_we, busy, fpu_start, stall}, wb_data, held); end
    end
    fpu_done = 1'b0;
  endtask

  task automatic test_long_wait();
    req = 1'b1; FPUControl = 2'b10; Rd = 4'd5; FPUFlagW = 1'b1; fpu_done = 1'b0;
    step();
    req = 1'b0;
    step();
    last_op = 2'b10;
`ifdef FPU_SEQ_TIMEOUT_EN
    for (int i = 0; i < 64; i++) begin
      n_cmp++; if ({err, busy, wb_en} !== 3'b010) begin n_bad++; $display("FAIL wd_wait got err/busy/wb=%b want 010", {err, busy, wb_en}); end
      step();
    end
    n_cmp++; if ({err, busy, wb_en, flag_we, stall} !== 5'b10000) begin n_bad++; $display("FAIL wd_err got err/busy/wb/fw/stall=%b want 10000", {err, busy, wb_en, flag_we, stall}); end
    n_cmp++; if (lat_cnt !== 8'd64) begin n_bad++; $display("FAIL wd_lat got %0d want 64", lat_cnt); end
    step();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wd_err_pulse got %b want 0", err); end
    for (int i = 0; i < 236; i++) begin
      fpu_done = (i == 200);
      step();
      n_cmp++; if ({wb_en, flag_we, err, busy} !== 4'b0) begin n_bad++; $display("FAIL wd_after got wb/fw/err/busy=%b want 0000", {wb_en, flag_we, err, busy}); end
    end
    fpu_done = 1'b0;
`else
    for (int i = 0; i < 300; i++) begin
      n_cmp++; if ({wb_en, err, stall, busy} !== 4'b0011) begin n_bad++; $display("FAIL long_wait got wb/err/stall/busy=%b want 0011", {wb_en, err, stall, busy}); end
      step();
    end
    n_cmp++; if (lat_cnt !== 8'd255) begin n_bad++; $display("FAIL long_lat got %0d want 255", lat_cnt); end
    fpu_done = 1'b1; fpu_result = 32'h40490FDB; fpu_flags = 2'b10;
    step();
    fpu_done = 1'b0;
    n_cmp++; if ({wb_en, flag_we} !== 2'b11 || wb_rd !== 4'd5 || wb_data !== 32'h40490FDB || lat_cnt !== 8'd255)
      begin n_bad++; $display("FAIL long_wb got wb=%b fw=%b rd=%h data=%h lat=%0d want 1 1 5 40490fdb 255", wb_en, flag_we, wb_rd, wb_data, lat_cnt); end
    step();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      do_txn(2'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 12)),
             $urandom, 2'($urandom), (i < 24) ? bit'($urandom % 2) : 1'b0);
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_fast_noflags();
    test_back_to_back();
    test_reset_in_wait();
    test_spurious_idle();
    test_long_wait();
    test_random();
    req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_seq.md
FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 SHALL provide clk, input, 1, rising-edge system clock; the only clock.
REQ-002 SHALL provide reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL provide req, input, 1: decoded FPU instruction valid with its condition passed (ResSrc path).
REQ-004 SHALL provide FPUControl, input, 2: FPU op, 00 add, 01 sub, 10 mul, 11 div.
REQ-005 SHALL provide FPUFlagW, input, 1: instruction requests flag update.
REQ-006 SHALL provide Rd, input, 4: destination register.
REQ-007 SHALL provide fpu_start, output, 1: one-cycle launch pulse to the iterative FPU.
REQ-008 SHALL provide fpu_op, output, 2: latched op, held stable from ISSUE through WAIT.
REQ-009 SHALL provide fpu_done, input, 1, and fpu_result, input, 32, and fpu_flags, input, 2: FPU completion, result, and N/Z flags.
REQ-010 SHALL provide stall, output, 1: freezes fetch/decode while the instruction is in flight.
REQ-011 SHALL provide wb_en, output, 1, and wb_rd, output, 4, and wb_data, output, 32: register-file write port.
REQ-012 SHALL provide flag_we, output, 1, and flags_out, output, 2: flag register update.
REQ-013 SHALL provide busy, output, 1, and lat_cnt, output, 8, and err, output, 1.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, WB.
REQ-015 IDLE & req: SHALL latch FPUControl, FPUFlagW, Rd, go to ISSUE next cycle; IDLE & !req: stay.
REQ-016 ISSUE: SHALL assert fpu_start for exactly one cycle, clear lat_cnt, go to WAIT.
REQ-017 WAIT: fpu_done high SHALL capture fpu_result and fpu_flags and go to WB; fpu_done low SHALL stay and increment lat_cnt.
REQ-018 lat_cnt SHALL saturate at 255 and hold its last value outside WAIT until the next ISSUE.
REQ-019 fpu_done SHALL be ignored in IDLE, ISSUE, and WB.
REQ-020 WB: SHALL assert wb_en for one cycle with the latched wb_rd and captured wb_data, assert flag_we equal to the latched FPUFlagW with flags_out equal to the captured flags, then go to IDLE.
REQ-021 stall SHALL be combinational: high when (IDLE & req), ISSUE, or WAIT; low in WB and idle.
REQ-022 busy SHALL be high in ISSUE, WAIT, and WB.
REQ-023 req SHALL be sampled only in IDLE; back-to-back instructions incur one IDLE cycle after WB.
REQ-024 Minimum latency SHALL be: req at cycle 0, fpu_start at 1, done at 2 at the earliest, wb_en at 3.
REQ-025 wb_en, flag_we, fpu_start, and err SHALL never be high in the same cycle as each other except wb_en with flag_we.

Reset
REQ-026 reset SHALL force IDLE on the next edge from any state, abandoning any in-flight op with no wb_en or flag_we.
REQ-027 After reset all outputs SHALL be 0, including latched op, wb_rd, wb_data, flags_out, and lat_cnt.
REQ-028 reset SHALL take priority over req and fpu_done in the same cycle.

Configuration
REQ-029 Macro FPU_SEQ_TIMEOUT_EN, when defined: a 6-bit watchdog counts WAIT cycles; on 64 consecutive WAIT cycles without fpu_done, SHALL go to IDLE, pulse err for one cycle, and suppress wb_en and flag_we.
REQ-030 Without FPU_SEQ_TIMEOUT_EN: WAIT SHALL persist indefinitely and err SHALL be constant 0.

Verification
REQ-031 Bench SHALL cover: req, op=10, Rd=3, FPUFlagW=1, done 4 cycles after fpu_start with result 0x3F800000 and flags 01 -> wb_en once with wb_rd=3, wb_data=0x3F800000, flag_we=1, flags_out=01, lat_cnt=4.
REQ-032 Bench SHALL cover: done on the first WAIT cycle with FPUFlagW=0 -> wb_en 3 cycles after req, flag_we=0, stall low in the WB cycle.
REQ-033 Bench SHALL cover: reset asserted in WAIT, then done the next cycle -> state IDLE, no wb_en, all outputs 0.
REQ-034 Bench SHALL cover: req held high across two instructions -> second fpu_start exactly 2 cycles after the first wb_en; fpu_op changes only at the second latch.
REQ-035 Bench SHALL cover: done held low for 300 cycles -> lat_cnt=255; with FPU_SEQ_TIMEOUT_EN, err pulses after 64 WAIT cycles and there is no wb_en.
REQ-036 Bench SHALL cover: spurious fpu_done in IDLE and WB -> no state change and no wb_en.
